// File: rtl/activity_window_ctrl.sv
// Step-count sequencer: 1-s window generation, per-window step statistics, high-activity tracking
// and display rotation. Optional macro PAUSE_EN adds a pause input that freezes everything.
module activity_window_ctrl #(
  parameter int unsigned TICK_DIV     = 100000000,
  parameter int unsigned OVER_THRESH  = 32,
  parameter int unsigned HIGH_THRESH  = 64,
  parameter int unsigned HIGH_MIN_SEC = 60,
  parameter int unsigned DISP_SEC     = 2
) (
  input  logic        clk100MHz,
  input  logic        reset,
`ifdef PAUSE_EN
  input  logic        pause,
`endif
  input  logic        step_pulse,
  output logic        sec_tick,
  output logic [7:0]  steps_last_sec,
  output logic [15:0] total_steps,
  output logic [15:0] seconds_over,
  output logic [15:0] high_act_sec,
  output logic [1:0]  disp_sel,
  output logic [15:0] disp_value
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned RW = $clog2(HIGH_MIN_SEC + 1);
  localparam int unsigned DW = (DISP_SEC > 1) ? $clog2(DISP_SEC) : 1;

  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DISP_MAX   = DW'(DISP_SEC - 1);
  localparam logic [15:0]   SAT_MAX    = 16'd9999;
  localparam logic [15:0]   MIN_CREDIT = (HIGH_MIN_SEC > 9999) ? 16'd9999 : 16'(HIGH_MIN_SEC);

  typedef enum logic [1:0] {StLow, StCand, StHigh} state_e;

  logic          w_run;
  logic          w_tick;
  logic          w_step;
  logic          w_over;
  logic          w_high;

  logic [PW-1:0] r_presc;
  logic [7:0]    r_win;
  logic [7:0]    r_last;
  logic [15:0]   r_total;
  logic [15:0]   r_over;
  logic [15:0]   r_high;
  logic [RW-1:0] r_run;
  state_e        r_state;
  logic [DW-1:0] r_disp_cnt;
  logic [1:0]    r_disp_sel;
  logic [15:0]   r_disp_value;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, inc};
    return (s > {1'b0, SAT_MAX}) ? SAT_MAX : s[15:0];
  endfunction

`ifdef PAUSE_EN
  assign w_run = ~pause;
`else
  assign w_run = 1'b1;
`endif

  assign w_tick = w_run & (r_presc == PRESC_MAX);
  assign w_step = w_run & step_pulse;
  assign w_over = 32'(r_win) >= OVER_THRESH;
  assign w_high = 32'(r_win) >= HIGH_THRESH;

  // Prescaler, window counter and per-step / per-window statistics
  always_ff @(posedge clk100MHz or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_win   <= '0;
      r_last  <= '0;
      r_total <= '0;
      r_over  <= '0;
    end else begin
      if (w_run) begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
      end
      if (w_tick) begin
        r_last <= r_win;
        // A step on the closing cycle opens the next window
        r_win  <= {7'd0, w_step};
        if (w_over) begin
          r_over <= sat_add(r_over, 16'd1);
        end
      end else if (w_step && (r_win != 8'hFF)) begin
        r_win <= r_win + 8'd1;
      end
      if (w_step) begin
        r_total <= sat_add(r_total, 16'd1);
      end
    end
  end

  // High-activity FSM: nothing is credited until HIGH_MIN_SEC consecutive high windows
  always_ff @(posedge clk100MHz or posedge reset) begin
    if (reset) begin
      r_state <= StLow;
      r_run   <= '0;
      r_high  <= '0;
    end else if (w_tick) begin
      unique case (r_state)
        StLow: begin
          if (w_high) begin
            if (HIGH_MIN_SEC <= 1) begin
              r_high  <= sat_add(r_high, 16'd1);
              r_state <= StHigh;
            end else begin
              r_run   <= RW'(1);
              r_state <= StCand;
            end
          end
        end
        StCand: begin
          if (!w_high) begin
            r_run   <= '0;
            r_state <= StLow;
          end else if (32'(r_run) + 1 == HIGH_MIN_SEC) begin
            r_high  <= sat_add(r_high, MIN_CREDIT);
            r_run   <= '0;
            r_state <= StHigh;
          end else begin
            r_run <= r_run + RW'(1);
          end
        end
        StHigh: begin
          if (w_high) begin
            r_high <= sat_add(r_high, 16'd1);
          end else begin
            r_state <= StLow;
          end
        end
        default: r_state <= StLow;
      endcase
    end
  end

  // Display rotation; the value mux is registered and so lags selection/metric changes by one cycle
  always_ff @(posedge clk100MHz or posedge reset) begin
    if (reset) begin
      r_disp_cnt   <= '0;
      r_disp_sel   <= '0;
      r_disp_value <= '0;
    end else begin
      if (w_tick) begin
        if (r_disp_cnt == DISP_MAX) begin
          r_disp_cnt <= '0;
          r_disp_sel <= r_disp_sel + 2'd1;
        end else begin
          r_disp_cnt <= r_disp_cnt + DW'(1);
        end
      end
      unique case (r_disp_sel)
        2'd0:    r_disp_value <= r_total;
        2'd1:    r_disp_value <= {8'd0, r_last};
        2'd2:    r_disp_value <= r_over;
        default: r_disp_value <= r_high;
      endcase
    end
  end

  assign sec_tick       = w_tick;
  assign steps_last_sec = r_last;
  assign total_steps    = r_total;
  assign seconds_over   = r_over;
  assign high_act_sec   = r_high;
  assign disp_sel       = r_disp_sel;
  assign disp_value     = r_disp_value;

endmodule

// File: tb/tb_activity_window_ctrl.sv
// Self-checking bench for activity_window_ctrl: table of windows with a tick-driven scoreboard,
// plus reset, pause and saturation sequences on a second, longer-window instance.
module tb_activity_window_ctrl;

  localparam int unsigned TD  = 100;
  localparam int unsigned TD2 = 400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        step_pulse;
  logic        step2;
`ifdef PAUSE_EN
  logic        pause;
`endif
  logic        sec_tick, sec_tick2;
  logic [7:0]  steps_last_sec, steps_last_sec2;
  logic [15:0] total_steps, seconds_over, high_act_sec, disp_value;
  logic [15:0] total_steps2, seconds_over2, high_act_sec2, disp_value2;
  logic [1:0]  disp_sel, disp_sel2;

  activity_window_ctrl #(
    .TICK_DIV(TD), .OVER_THRESH(32), .HIGH_THRESH(64), .HIGH_MIN_SEC(3), .DISP_SEC(2)
  ) dut (
    .clk100MHz(clk), .reset(reset),
`ifdef PAUSE_EN
    .pause(pause),
`endif
    .step_pulse(step_pulse), .sec_tick(sec_tick), .steps_last_sec(steps_last_sec),
    .total_steps(total_steps), .seconds_over(seconds_over), .high_act_sec(high_act_sec),
    .disp_sel(disp_sel), .disp_value(disp_value)
  );

  activity_window_ctrl #(
    .TICK_DIV(TD2), .OVER_THRESH(32), .HIGH_THRESH(64), .HIGH_MIN_SEC(3), .DISP_SEC(2)
  ) dut2 (
    .clk100MHz(clk), .reset(reset),
`ifdef PAUSE_EN
    .pause(pause),
`endif
    .step_pulse(step2), .sec_tick(sec_tick2), .steps_last_sec(steps_last_sec2),
    .total_steps(total_steps2), .seconds_over(seconds_over2), .high_act_sec(high_act_sec2),
    .disp_sel(disp_sel2), .disp_value(disp_value2)
  );

  typedef struct {
    int n;
    bit tstep;
    int last;
    int total;
    int over;
    int high;
    int sel;
  } win_t;

  win_t tbl[21];
  win_t sbq[$];
  win_t cur;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int metric(input win_t w);
    case (w.sel)
      0:       return w.total;
      1:       return w.last;
      2:       return w.over;
      default: return w.high;
    endcase
  endfunction

  // Scoreboard monitor: a tick seen at a negedge closes the window on the next posedge
  bit mon_en      = 1'b0;
  bit skip_period = 1'b0;
  bit have_prev   = 1'b0;
  bit p1          = 1'b0;
  bit p2          = 1'b0;
  int since       = 0;

  always @(negedge clk) begin
    if (reset || !mon_en) begin
      p1 = 1'b0; p2 = 1'b0; have_prev = 1'b0; since = 0;
    end else begin
      since++;
      if (p2) begin
        p2 = 1'b0;
        check("disp_value", int'(disp_value), metric(cur));
      end
      if (p1) begin
        p1 = 1'b0;
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_tick: got tick expected none (t=%0t)", $time);
        end else begin
          cur = sbq.pop_front();
          check("steps_last_sec", int'(steps_last_sec), cur.last);
          check("total_steps", int'(total_steps), cur.total);
          check("seconds_over", int'(seconds_over), cur.over);
          check("high_act_sec", int'(high_act_sec), cur.high);
          check("disp_sel", int'(disp_sel), cur.sel);
          p2 = 1'b1;
        end
      end
      if (sec_tick) begin
        if (have_prev && !skip_period) check("tick_period", since, TD);
        skip_period = 1'b0;
        have_prev   = 1'b1;
        since       = 0;
        p1          = 1'b1;
      end
    end
  end

  task automatic drive_window(input int n, input bit tstep);
    for (int i = 0; i < TD; i++) begin
      step_pulse = (i < n) || ((i == TD - 1) && tstep);
      @(negedge clk);
    end
    step_pulse = 1'b0;
  endtask

  initial begin
    int cnt;
    int tick_seen;
    win_t w;

    reset      = 1'b1;
    step_pulse = 1'b0;
    step2      = 1'b0;
`ifdef PAUSE_EN
    pause      = 1'b0;
`endif
    // {n, step on tick cycle, last, total, over, high, sel}
    tbl = '{
      '{0, 0, 0, 0, 0, 0, 0},     '{0, 0, 0, 0, 0, 0, 1},     '{0, 0, 0, 0, 0, 0, 1},
      '{0, 0, 0, 0, 0, 0, 2},     '{0, 0, 0, 0, 0, 0, 2},     '{40, 0, 40, 40, 1, 0, 3},
      '{10, 0, 10, 50, 1, 0, 3},  '{31, 1, 31, 82, 1, 0, 0},  '{0, 0, 1, 82, 1, 0, 0},
      '{70, 0, 70, 152, 2, 0, 1}, '{70, 0, 70, 222, 3, 0, 1}, '{10, 0, 10, 232, 3, 0, 2},
      '{70, 0, 70, 302, 4, 0, 2}, '{70, 0, 70, 372, 5, 0, 3}, '{70, 0, 70, 442, 6, 3, 3},
      '{70, 0, 70, 512, 7, 4, 0}, '{0, 0, 0, 512, 7, 4, 0},   '{64, 0, 64, 576, 8, 4, 1},
      '{63, 0, 63, 639, 9, 4, 1}, '{32, 0, 32, 671, 10, 4, 2}, '{31, 0, 31, 702, 10, 4, 2}
    };

    repeat (3) @(negedge clk);
    check("reset_total", int'(total_steps), 0);
    check("reset_disp_sel", int'(disp_sel), 0);
    mon_en = 1'b1;
    reset  = 1'b0;

    for (int k = 0; k < 21; k++) begin
      sbq.push_back(tbl[k]);
      drive_window(tbl[k].n, tbl[k].tstep);
    end

`ifdef PAUSE_EN
    // 20 steps, pause 250 cycles with ignored steps, then 5 more steps
    skip_period = 1'b1;
    w = '{25, 0, 25, 727, 10, 4, 3};
    sbq.push_back(w);
    for (int i = 0; i < 30; i++) begin
      step_pulse = (i < 20);
      @(negedge clk);
    end
    pause     = 1'b1;
    tick_seen = 0;
    for (int i = 0; i < 250; i++) begin
      step_pulse = i[0];
      @(negedge clk);
      if (sec_tick) tick_seen++;
    end
    check("pause_no_tick", tick_seen, 0);
    check("pause_total_frozen", int'(total_steps), 722);
    pause = 1'b0;
    for (int i = 30; i < TD; i++) begin
      step_pulse = (i < 35);
      @(negedge clk);
    end
    step_pulse = 1'b0;
`endif

    // Reset at cycle 50 of a window holding 20 steps
    for (int i = 0; i < 50; i++) begin
      step_pulse = (i < 20);
      @(negedge clk);
    end
    step_pulse = 1'b0;
    reset      = 1'b1;
    #1;
    check("async_sec_tick", int'(sec_tick), 0);
    check("async_last", int'(steps_last_sec), 0);
    check("async_total", int'(total_steps), 0);
    check("async_over", int'(seconds_over), 0);
    check("async_high", int'(high_act_sec), 0);
    check("async_disp_sel", int'(disp_sel), 0);
    check("async_disp_value", int'(disp_value), 0);
    repeat (3) @(negedge clk);
    w = '{0, 0, 0, 0, 0, 0, 0};
    sbq.push_back(w);
    reset = 1'b0;
    cnt   = 0;
    while (!sec_tick && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    check("reset_tick_delay", cnt, TD - 1);
    repeat (3) @(negedge clk);
    check("sb_drain", sbq.size(), 0);

    // Saturation on the 400-cycle instance: a step every cycle
    mon_en = 1'b0;
    reset  = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    step2 = 1'b1;
    for (int k = 1; k <= 30 * TD2; k++) begin
      @(negedge clk);
      if (k == TD2) begin
        check("sat_last_255", int'(steps_last_sec2), 255);
        check("sat_total_400", int'(total_steps2), 400);
      end
      if (k == 9998) check("sat_total_9998", int'(total_steps2), 9998);
      if (k == 9999) check("sat_total_9999", int'(total_steps2), 9999);
      if (k == 10000) check("sat_total_hold", int'(total_steps2), 9999);
    end
    step2 = 1'b0;
    check("sat_total_end", int'(total_steps2), 9999);
    check("sat_last_end", int'(steps_last_sec2), 255);
    check("sat_over_end", int'(seconds_over2), 30);
    check("sat_high_end", int'(high_act_sec2), 30);
    check("sat_disp_sel", int'(disp_sel2), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
